// File: rtl/stream_rsc_encoder.sv
// -----------------------------------------------------------------------------
// stream_rsc_encoder
//
// Streaming rate-1/2 recursive systematic convolutional encoder with trellis
// termination. It takes one information bit per input handshake and emits one
// coded symbol per output handshake. After SYMBOLS data symbols, M tail symbols
// drive the trellis back to state 0, so every frame is SYMBOLS+M symbols long.
//
// Ports:
//   clk         clock
//   rstn        asynchronous active-low reset
//   in_valid    in_bit is valid
//   in_ready    encoder accepts in_bit this cycle (combinational)
//   in_bit      information bit
//   out_valid   output symbol valid
//   out_ready   downstream accepts the symbol
//   out_symbol  {sys, par}, sys is the MSB
//   out_sys     BPSK-mapped systematic bit (0 -> +1.0, 1 -> -1.0)
//   out_par     BPSK-mapped parity bit
//   out_tail    symbol is a termination symbol
//   out_last    final tail symbol of the frame
//   busy        a frame is in progress
// -----------------------------------------------------------------------------
module stream_rsc_encoder #(
    parameter int                      BITS      = 16,
    parameter string                   PRECISION = "HALF",
    parameter int                      STATES    = 4,
    parameter int                      SYMBOLS   = 10,
    parameter logic [$clog2(STATES):0] FB_POLY   = 3'b111,
    parameter logic [$clog2(STATES):0] FF_POLY   = 3'b101
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_bit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_symbol,
    output logic [BITS-1:0] out_sys,
    output logic [BITS-1:0] out_par,
    output logic            out_tail,
    output logic            out_last,
    output logic            busy
);

    localparam int M     = $clog2(STATES);
    localparam int CNT_W = $clog2(SYMBOLS + 1);
    localparam int TC_W  = (M > 1) ? $clog2(M) : 1;

    localparam logic [BITS-1:0] POS_ONE = (PRECISION == "SINGLE") ?
                                          BITS'(32'h3F80_0000) : BITS'(16'h3C00);
    localparam logic [BITS-1:0] NEG_ONE = (PRECISION == "SINGLE") ?
                                          BITS'(32'hBF80_0000) : BITS'(16'hBC00);

    typedef enum logic {
        ST_DATA,
        ST_TAIL
    } state_t;

    // Bit 0 -> +1.0, bit 1 -> -1.0
    function automatic logic [BITS-1:0] bpsk_map(input logic b);
        return b ? NEG_ONE : POS_ONE;
    endfunction

    // Feedback contribution of the delay line (excludes the input tap).
    // s[0] is the newest register, so polynomial bit j taps s[M-1-j].
    function automatic logic fb_tap_sum(input logic [M-1:0] s);
        logic r;
        r = 1'b0;
        for (int j = 0; j < M; j++) begin
            r = r ^ (FB_POLY[j] & s[M-1-j]);
        end
        return r;
    endfunction

    // Feedforward contribution of the delay line (excludes the D^0 tap).
    function automatic logic ff_tap_sum(input logic [M-1:0] s);
        logic r;
        r = 1'b0;
        for (int j = 0; j < M; j++) begin
            r = r ^ (FF_POLY[j] & s[M-1-j]);
        end
        return r;
    endfunction

    state_t           fsm;
    logic [M-1:0]     enc_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [TC_W-1:0]  tail_cnt;

    // Output register stage
    logic             vld_p0;
    logic [1:0]       sym_p0;
    logic [BITS-1:0]  sys_p0;
    logic [BITS-1:0]  par_p0;
    logic             tail_p0;
    logic             last_p0;

    logic             slot_free;
    logic             load;
    logic             enc_u;
    logic             enc_a;
    logic             enc_p;
    logic [M:0]       shifted;
    logic [M-1:0]     state_nxt;

    assign slot_free = !vld_p0 || out_ready;
    assign in_ready  = rstn && slot_free && (fsm == ST_DATA);
    assign load      = (fsm == ST_DATA) ? (in_valid && in_ready) : slot_free;

    // In TAIL the input equals the feedback sum, which forces a = 0 and
    // shifts a zero into the delay line on every termination step.
    always_comb begin
        enc_u     = (fsm == ST_TAIL) ? fb_tap_sum(enc_state) : in_bit;
        enc_a     = enc_u ^ fb_tap_sum(enc_state);
        enc_p     = (FF_POLY[M] & enc_a) ^ ff_tap_sum(enc_state);
        shifted   = {enc_state, enc_a};
        state_nxt = shifted[M-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm       <= ST_DATA;
            enc_state <= '0;
            bit_cnt   <= '0;
            tail_cnt  <= '0;
            vld_p0    <= 1'b0;
            sym_p0    <= 2'b00;
            sys_p0    <= POS_ONE;
            par_p0    <= POS_ONE;
            tail_p0   <= 1'b0;
            last_p0   <= 1'b0;
        end else begin
            if (load) begin
                enc_state <= state_nxt;
                vld_p0    <= 1'b1;
                sym_p0    <= {enc_u, enc_p};
                sys_p0    <= bpsk_map(enc_u);
                par_p0    <= bpsk_map(enc_p);
                if (fsm == ST_DATA) begin
                    tail_p0 <= 1'b0;
                    last_p0 <= 1'b0;
                    if (bit_cnt == CNT_W'(SYMBOLS - 1)) begin
                        bit_cnt  <= '0;
                        tail_cnt <= '0;
                        fsm      <= ST_TAIL;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end else begin
                    tail_p0 <= 1'b1;
                    if (tail_cnt == TC_W'(M - 1)) begin
                        last_p0  <= 1'b1;
                        tail_cnt <= '0;
                        fsm      <= ST_DATA;
                    end else begin
                        last_p0  <= 1'b0;
                        tail_cnt <= tail_cnt + TC_W'(1);
                    end
                end
            end else if (out_ready) begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign out_valid  = vld_p0;
    assign out_symbol = sym_p0;
    assign out_sys    = sys_p0;
    assign out_par    = par_p0;
    assign out_tail   = tail_p0;
    assign out_last   = last_p0;
    assign busy       = (bit_cnt != '0) || (fsm == ST_TAIL);

endmodule

// File: tb/tb_stream_rsc_encoder.sv
module tb_stream_rsc_encoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    // Half-precision instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_bit = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_symbol;
    logic [15:0] out_sys;
    logic [15:0] out_par;
    logic        out_tail;
    logic        out_last;
    logic        busy;

    // Single-precision instance
    logic        in_valid_s = 1'b0;
    logic        in_ready_s;
    logic        in_bit_s = 1'b0;
    logic        out_valid_s;
    logic        out_ready_s = 1'b1;
    logic [1:0]  out_symbol_s;
    logic [31:0] out_sys_s;
    logic [31:0] out_par_s;
    logic        out_tail_s;
    logic        out_last_s;
    logic        busy_s;

    int checks = 0;
    int fails  = 0;

    logic [1:0]  got_sym  [32];
    logic        got_tail [32];
    logic        got_last [32];
    logic        got_busy [32];
    logic [15:0] got_sys  [32];
    logic [15:0] got_par  [32];
    int          got_cnt;
    int          stall_bad;
    int          ready_bad;
    int          stall_seen;
    int          gap_cnt;

    always #5 clk = ~clk;

    stream_rsc_encoder #(
        .BITS(16), .PRECISION("HALF"), .STATES(4), .SYMBOLS(4),
        .FB_POLY(3'b111), .FF_POLY(3'b101)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_symbol(out_symbol), .out_sys(out_sys), .out_par(out_par),
        .out_tail(out_tail), .out_last(out_last), .busy(busy)
    );

    stream_rsc_encoder #(
        .BITS(32), .PRECISION("SINGLE"), .STATES(4), .SYMBOLS(4),
        .FB_POLY(3'b111), .FF_POLY(3'b101)
    ) dut_s (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_bit(in_bit_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .out_symbol(out_symbol_s), .out_sys(out_sys_s), .out_par(out_par_s),
        .out_tail(out_tail_s), .out_last(out_last_s), .busy(busy_s)
    );

    // Drives nbits input bits (bv[0] first) and records every accepted
    // output symbol until expect_n are collected or the cycle budget expires.
    // rmode 0: out_ready held high; rmode 1: out_ready pattern 1,0,0,1,...
    task automatic stream(input int nbits, input logic [15:0] bv,
                          input int rmode, input int expect_n);
        int cyc = 0;
        int sent = 0;
        logic prev_stall = 1'b0;
        logic [36:0] snap = '0;
        got_cnt = 0; stall_bad = 0; ready_bad = 0; stall_seen = 0; gap_cnt = 0;
        while (got_cnt < expect_n && cyc < 200) begin
            @(negedge clk);
            if (prev_stall &&
                {out_valid, out_symbol, out_tail, out_last, out_sys, out_par} !== snap)
                stall_bad++;
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            if (sent < nbits) begin
                in_valid = 1'b1;
                in_bit   = bv[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stall_seen++;
                if (in_ready) ready_bad++;
            end
            if (in_valid && in_ready) sent++;
            if (got_cnt > 0 && !out_valid) gap_cnt++;
            if (out_valid && out_ready) begin
                got_sym[got_cnt]  = out_symbol;
                got_tail[got_cnt] = out_tail;
                got_last[got_cnt] = out_last;
                got_busy[got_cnt] = busy;
                got_sys[got_cnt]  = out_sys;
                got_par[got_cnt]  = out_par;
                got_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            snap = {out_valid, out_symbol, out_tail, out_last, out_sys, out_par};
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got_cnt !== expect_n) begin
            fails++;
            $display("FAIL symbol_count: got %0d, expected %0d", got_cnt, expect_n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks += 8;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        if (out_symbol !== 2'b00) begin fails++; $display("FAIL rst_out_symbol: got %b, expected 00", out_symbol); end
        if (out_tail !== 1'b0) begin fails++; $display("FAIL rst_out_tail: got %b, expected 0", out_tail); end
        if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last: got %b, expected 0", out_last); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (out_sys !== 16'h3C00) begin fails++; $display("FAIL rst_out_sys: got %h, expected 3c00", out_sys); end
        if (out_par !== 16'h3C00) begin fails++; $display("FAIL rst_out_par: got %h, expected 3c00", out_par); end
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready: got %b, expected 1", in_ready); end
    endtask

    // Checks the recorded 1,0,1,1 frame: 11,01,10,10 then tail 01,11
    task automatic check_frame_1011(input string tag);
        logic [1:0] exp_sym [6] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        logic       exp_tl  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_ls  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({got_sym[k], got_tail[k], got_last[k]} !== {exp_sym[k], exp_tl[k], exp_ls[k]}) begin
                fails++;
                $display("FAIL %s_sym%0d: got sym=%b tail=%b last=%b, expected sym=%b tail=%b last=%b",
                         tag, k, got_sym[k], got_tail[k], got_last[k], exp_sym[k], exp_tl[k], exp_ls[k]);
            end
        end
    endtask

    task automatic test_basic();
        stream(4, 16'h000D, 0, 6);
        check_frame_1011("basic");
        checks += 3;
        if (got_sys[0] !== 16'hBC00) begin fails++; $display("FAIL basic_sys0: got %h, expected bc00", got_sys[0]); end
        if (got_par[0] !== 16'hBC00) begin fails++; $display("FAIL basic_par0: got %h, expected bc00", got_par[0]); end
        if (gap_cnt !== 0) begin fails++; $display("FAIL basic_gaps: got %0d idle cycles, expected 0", gap_cnt); end
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_idle_valid: got %b, expected 0", out_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_backpressure();
        stream(4, 16'h000D, 1, 6);
        check_frame_1011("bp");
        checks += 3;
        if (stall_seen == 0) begin fails++; $display("FAIL bp_stall_seen: got 0 stalls, expected >0"); end
        if (stall_bad !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes during stall, expected 0", stall_bad); end
        if (ready_bad !== 0) begin fails++; $display("FAIL bp_in_ready: got %0d stalled cycles with in_ready=1, expected 0", ready_bad); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        stream(8, 16'h000D, 0, 12);
        check_frame_1011("b2b_f1");
        for (int k = 6; k < 12; k++) begin
            checks++;
            if ({got_sym[k], got_tail[k], got_last[k]} !== {2'b00, (k >= 10), (k == 11)}) begin
                fails++;
                $display("FAIL b2b_f2_sym%0d: got sym=%b tail=%b last=%b, expected sym=00 tail=%b last=%b",
                         k, got_sym[k], got_tail[k], got_last[k], (k >= 10), (k == 11));
            end
        end
        checks++;
        if (gap_cnt !== 0) begin fails++; $display("FAIL b2b_gaps: got %0d idle cycles, expected 0", gap_cnt); end
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        stream(4, 16'h0000, 0, 6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({got_sym[k], got_sys[k], got_par[k]} !== {2'b00, 16'h3C00, 16'h3C00}) begin
                fails++;
                $display("FAIL zero_sym%0d: got sym=%b sys=%h par=%h, expected sym=00 sys=3c00 par=3c00",
                         k, got_sym[k], got_sys[k], got_par[k]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got_busy[k] !== 1'b1) begin fails++; $display("FAIL zero_busy%0d: got %b, expected 1", k, got_busy[k]); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_after: got %b, expected 0", busy); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(negedge clk);
        in_bit = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_out_valid: got %b, expected 0", out_valid); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mrst_busy: got %b, expected 0", busy); end
        if (in_ready !== 1'b0) begin fails++; $display("FAIL mrst_in_ready: got %b, expected 0", in_ready); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL mrst_out_valid2: got %b, expected 0", out_valid); end
        rstn = 1'b1;
        stream(4, 16'h000D, 0, 6);
        check_frame_1011("mrst");
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid_s = 1'b1;
        in_bit_s = 1'b1;
        #1;
        checks++;
        if (in_ready_s !== 1'b1) begin fails++; $display("FAIL single_in_ready: got %b, expected 1", in_ready_s); end
        @(negedge clk);
        in_valid_s = 1'b0;
        checks += 3;
        if (out_valid_s !== 1'b1) begin fails++; $display("FAIL single_valid: got %b, expected 1", out_valid_s); end
        if (out_sys_s !== 32'hBF80_0000) begin fails++; $display("FAIL single_sys: got %h, expected bf800000", out_sys_s); end
        if ({out_symbol_s, out_par_s} !== {2'b11, 32'hBF80_0000}) begin
            fails++;
            $display("FAIL single_par: got sym=%b par=%h, expected sym=11 par=bf800000", out_symbol_s, out_par_s);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_all_zero();
        test_mid_reset();
        test_single();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
